share_out_packer: RTL and testbench
===================================

Name: share_out_packer

Overview:
- Downstream consumer of simd_muland.
- Captures each {ps, sc} result pair (2 x prng_t, 256 b each) when it leaves the 8-stage pipeline and buffers it in a small FIFO.
- Serializes buffered pairs onto a 64-bit valid/ready stream with packet framing.
- simd_muland cannot stall, so this block issues credits (issue_ok_o) to the upstream issue controller. Results in flight are therefore always guaranteed a FIFO slot.

Parameters:
- W_OUT, 64, output beat width; must divide 512.
- FIFO_DEPTH, 16, result-pair entries; power of two, >= 2.
- PAIRS_PER_PKT, 4, result pairs per output packet; >= 1.
- MAX_INFLIGHT, 15, saturation bound of the in-flight counter; >= pipeline depth 8.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- issue_i  in  1  pulse: upstream launched one operation into simd_muland this cycle.
- valid_i  in  1  ps_i/sc_i carry a result this cycle (issue_i delayed by pipeline depth).
- ps_i  in  256  prng_t partial-sum result.
- sc_i  in  256  prng_t carry/AND result.
- issue_ok_o  out  1  upstream may assert issue_i this cycle.
- m_data_o  out  W_OUT  output beat.
- m_valid_o  out  1  beat valid.
- m_ready_i  in  1  sink ready.
- m_last_o  out  1  last beat of packet.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - outputs: m_valid_o=0, m_last_o=0, m_data_o=0, err_o=0, issue_ok_o=1.
  - internal: FIFO empty, inflight=0, beat_cnt=0, pair_cnt=0.
  - Reset mid-packet discards buffered data and any partial packet; the first post-reset beat starts a new packet.
- Credit accounting:
  - inflight +1 on issue_i, -1 on valid_i, unchanged when both occur.
  - issue_ok_o = (fifo_count + inflight) < FIFO_DEPTH, decoded from registered state only.
  - Asserting issue_i while issue_ok_o=0 sets err_o; inflight saturates at MAX_INFLIGHT.
- Push: on valid_i, entry {sc_i, ps_i} (sc in bits [511:256]) is written at the clock edge.
  - Push while full with no same-cycle pop: entry dropped, err_o set.
  - Push while full with a same-cycle final-beat pop: accepted.
  - valid_i while inflight=0: err_o set; data still pushed if space.
- Output serializer:
  - m_valid_o = FIFO non-empty.
  - m_data_o = head[W_OUT*beat_cnt +: W_OUT], so ps[63:0] is beat 0 and sc[255:192] is beat 7 (at W_OUT=64).
  - beat_cnt advances on m_valid_o & m_ready_i. At 512/W_OUT-1 it wraps to 0 and the head is popped.
  - m_last_o = m_valid_o & (beat_cnt == last) & (pair_cnt == PAIRS_PER_PKT-1). pair_cnt increments on each pop and wraps at PAIRS_PER_PKT.
  - While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable.
- Latency: a pair pushed at edge t is visible on m_data_o in cycle t+1 if the FIFO was empty. Empty-FIFO throughput is one beat per cycle.
- Simultaneous push and pop: fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- err_o clears only on reset.

Decomposition:
- Shared package TYPES:
  - prng_t (existing).
  - new pair_t: packed struct {prng_t sc; prng_t ps}.
  - constant W_PAIR = 512.
- One sub-module: sync_fifo (parameterized width/depth; push, pop, full, empty, count). The serializer and credit logic stay in share_out_packer.

Test Plan:
- Single pair, m_ready_i=1: ps=0x..0001_..., sc=0xFFFF...FFFF, issue_i then valid_i 8 cycles later -> 8 consecutive beats; beat0 = ps[63:0], beats 4-7 = 0xFFFF_FFFF_FFFF_FFFF; m_last_o=0 (pair 1 of 4).
- 4 back-to-back pairs, m_ready_i=1 -> 32 beats; m_last_o high only on beat 32; issue_ok_o never drops.
- m_ready_i=0 throughout, upstream issues whenever issue_ok_o=1 -> exactly 16 issues accepted; issue_ok_o low after the 16th; no err_o; releasing ready drains 128 beats in order.
- Backpressure toggle (ready 1-0-0-1 pattern) mid-pair -> m_data_o stable during stalls; no beat lost or duplicated vs reference model.
- Issue with issue_ok_o=0, or valid_i with inflight=0 -> err_o=1 next cycle and stays 1 until rst_n_i low.
- Assert rst_n_i low asynchronously at beat 3 of pair 2 -> m_valid_o=0 immediately; after release, the next pair starts at beat 0 with pair_cnt=0.

Source files
------------

// File: rtl/share_out_packer_pkg.sv
// Shared types for the simd_muland result path: prng_t words, the {sc, ps}
// result pair as it is buffered, and small sizing helpers.
package share_out_packer_pkg;

  localparam int PRNG_W     = 256;
  localparam int W_PAIR     = 512;
  localparam int PIPE_DEPTH = 8;

  typedef logic [PRNG_W-1:0] prng_t;

  // sc occupies the upper half so ps[63:0] is the first beat on the wire
  typedef struct packed {
    prng_t sc;
    prng_t ps;
  } pair_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/share_out_packer_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count. A push while
// full is only accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against current occupancy
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != '0)) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r != CW'(DEPTH)) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/share_out_packer.sv
// Buffers simd_muland {ps, sc} result pairs, serializes them into framed
// W_OUT-bit packets, and grants issue credits so results are never dropped.
module share_out_packer
  import share_out_packer_pkg::*;
#(
  parameter int W_OUT         = 64,
  parameter int FIFO_DEPTH    = 16,
  parameter int PAIRS_PER_PKT = 4,
  parameter int MAX_INFLIGHT  = 15
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             issue_i,
  input  logic             valid_i,
  input  prng_t            ps_i,
  input  prng_t            sc_i,
  output logic             issue_ok_o,
  output logic [W_OUT-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic             err_o
);

  localparam int BEATS     = W_PAIR / W_OUT;
  localparam int BW        = cnt_width(BEATS);
  localparam int PW        = cnt_width(PAIRS_PER_PKT);
  localparam int IW        = $clog2(MAX_INFLIGHT + 1);
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int SW        = ((IW > CW) ? IW : CW) + 1;

  pair_t                       wr_pair_s;
  logic [W_PAIR-1:0]           head_bits_s;
  logic [BEATS-1:0][W_OUT-1:0] head_beats_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic [CW-1:0]               fifo_count_s;

  logic [BW-1:0] beat_cnt_r, beat_cnt_nxt_s;
  logic [PW-1:0] pair_cnt_r, pair_cnt_nxt_s;
  logic [IW-1:0] inflight_r, inflight_nxt_s;
  logic          err_r, err_nxt_s;
  logic          beat_fire_s, last_beat_s, last_pair_s, pop_s;
  logic [SW-1:0] credit_sum_s;

  assign wr_pair_s = '{sc: sc_i, ps: ps_i};

  sync_fifo #(
    .WIDTH (W_PAIR),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (valid_i),
    .wdata   (wr_pair_s),
    .pop     (pop_s),
    .rdata   (head_bits_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign head_beats_s = head_bits_s;

  // Serializer decode: beat selection, framing and pop
  always_comb begin
    m_valid_o   = ~fifo_empty_s;
    last_beat_s = (beat_cnt_r == BW'(BEATS - 1));
    last_pair_s = (pair_cnt_r == PW'(PAIRS_PER_PKT - 1));
    beat_fire_s = m_valid_o & m_ready_i;
    pop_s       = beat_fire_s & last_beat_s;
    m_last_o    = m_valid_o & last_beat_s & last_pair_s;
    if (m_valid_o) begin
      m_data_o = head_beats_s[beat_cnt_r];
    end else begin
      m_data_o = '0;
    end
    beat_cnt_nxt_s = beat_cnt_r;
    pair_cnt_nxt_s = pair_cnt_r;
    if (beat_fire_s) begin
      beat_cnt_nxt_s = last_beat_s ? '0 : beat_cnt_r + BW'(1);
    end else begin
      beat_cnt_nxt_s = beat_cnt_r;
    end
    if (pop_s) begin
      pair_cnt_nxt_s = last_pair_s ? '0 : pair_cnt_r + PW'(1);
    end else begin
      pair_cnt_nxt_s = pair_cnt_r;
    end
  end

  // Credit accounting: every issued op holds a slot until its result lands
  always_comb begin
    credit_sum_s   = SW'(fifo_count_s) + SW'(inflight_r);
    issue_ok_o     = (credit_sum_s < SW'(FIFO_DEPTH));
    inflight_nxt_s = inflight_r;
    case ({issue_i, valid_i})
      2'b10: begin
        if (inflight_r != IW'(MAX_INFLIGHT)) begin
          inflight_nxt_s = inflight_r + IW'(1);
        end else begin
          inflight_nxt_s = inflight_r;
        end
      end
      2'b01: begin
        if (inflight_r != '0) begin
          inflight_nxt_s = inflight_r - IW'(1);
        end else begin
          inflight_nxt_s = inflight_r;
        end
      end
      default: inflight_nxt_s = inflight_r;
    endcase
    err_nxt_s = err_r
              | (issue_i & ~issue_ok_o)
              | (valid_i & (inflight_r == '0))
              | (valid_i & fifo_full_s & ~pop_s);
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beat_cnt_r <= '0;
      pair_cnt_r <= '0;
      inflight_r <= '0;
      err_r      <= 1'b0;
    end else begin
      beat_cnt_r <= beat_cnt_nxt_s;
      pair_cnt_r <= pair_cnt_nxt_s;
      inflight_r <= inflight_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign err_o = err_r;

endmodule

// File: tb/tb_share_out_packer.sv
// Directed bench for share_out_packer: an 8-deep issue->valid pipeline model
// feeds the DUT, and a beat scoreboard checks data/framing on every handshake.
`timescale 1ns/1ps
module tb_share_out_packer;
  import share_out_packer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        issue_i;
  logic        valid_i;
  prng_t       ps_i;
  prng_t       sc_i;
  logic        issue_ok_o;
  logic [63:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_last_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  share_out_packer #(
    .W_OUT(64), .FIFO_DEPTH(16), .PAIRS_PER_PKT(4), .MAX_INFLIGHT(15)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .issue_i(issue_i), .valid_i(valid_i),
    .ps_i(ps_i), .sc_i(sc_i), .issue_ok_o(issue_ok_o), .m_data_o(m_data_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .err_o(err_o)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  logic  pipe_v [8];
  pair_t pipe_d [8];
  int    model_pair;
  int    beats_seen = 0;
  logic  prev_stall;
  logic [63:0] prev_data;
  logic  prev_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pair_t mk_pair(input int n);
    logic [7:0][63:0] bb;
    for (int b = 0; b < 8; b++) bb[b] = {16'(n), 16'(b), 32'(n * 37 + b) ^ 32'hA5A5_0F0F};
    return pair_t'(bb);
  endfunction

  function automatic bit tb_busy();
    bit busy = (exp_q.size() != 0);
    for (int i = 0; i < 8; i++) busy = busy | pipe_v[i];
    return busy;
  endfunction

  task automatic push_expected(input pair_t p);
    logic [7:0][63:0] bb;
    bb = p;
    for (int b = 0; b < 8; b++) exp_q.push_back({bb[b], (b == 7) && (model_pair == 3)});
    model_pair = (model_pair + 1) % 4;
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the pipe model
  task automatic cycle(input logic iss, input pair_t d, input logic rdy);
    beat_t e;
    issue_i   = iss;
    m_ready_i = rdy;
    valid_i   = pipe_v[7];
    {sc_i, ps_i} = pipe_d[7];
    if (pipe_v[7]) push_expected(pipe_d[7]);
    @(negedge clk_i);
    if (prev_stall) begin
      chk("stall_valid", 64'(m_valid_o), 64'd1);
      chk("stall_data", m_data_o, prev_data);
      chk("stall_last", 64'(m_last_o), 64'(prev_last));
    end
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 64'(m_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_data_o, e.data);
        chk("beat_last", 64'(m_last_o), 64'(e.last));
        beats_seen++;
      end
    end
    prev_stall = m_valid_o && !m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    @(posedge clk_i);
    #1;
    for (int i = 7; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = iss;
    pipe_d[0] = d;
  endtask

  task automatic do_reset();
    rst_n_i   = 1'b0;
    issue_i   = 1'b0;
    valid_i   = 1'b0;
    m_ready_i = 1'b0;
    ps_i      = '0;
    sc_i      = '0;
    exp_q.delete();
    model_pair = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    #2;
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_last", 64'(m_last_o), 64'd0);
    chk("rst_data", m_data_o, 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    chk("rst_issue_ok", 64'(issue_ok_o), 64'd1);
  endtask

  task automatic drain(input int maxc, input bit toggle);
    int c = 0;
    while (c < maxc && tb_busy()) begin
      cycle(1'b0, '0, toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1);
      c++;
    end
    chk("drain_done", 64'(tb_busy()), 64'd0);
  endtask

  initial begin
    pair_t p1;
    int n_iss;
    int bs0;
    rst_n_i = 1'b0;

    // 1: single pair, cycle-exact latency, ps then all-ones sc beats
    do_reset();
    p1.ps = {64'h3333_0001_0000_0003, 64'h2222_0001_0000_0002,
             64'h1111_0001_0000_0001, 64'h0000_0001_0000_0000};
    p1.sc = {256{1'b1}};
    cycle(1'b1, p1, 1'b1);
    repeat (7) cycle(1'b0, '0, 1'b1);
    chk("lat_before_push", 64'(m_valid_o), 64'd0);
    cycle(1'b0, '0, 1'b1);
    chk("lat_valid", 64'(m_valid_o), 64'd1);
    chk("lat_beat0", m_data_o, 64'h0000_0001_0000_0000);
    drain(40, 1'b0);
    chk("single_err", 64'(err_o), 64'd0);

    // 2: one full packet back-to-back, credits never exhausted
    do_reset();
    bs0 = beats_seen;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_issue_ok", 64'(issue_ok_o), 64'd1);
      cycle(1'b1, mk_pair(k + 10), 1'b1);
    end
    for (int c = 0; c < 60 && tb_busy(); c++) begin
      chk("b2b_issue_ok", 64'(issue_ok_o), 64'd1);
      cycle(1'b0, '0, 1'b1);
    end
    chk("b2b_beats", 64'(beats_seen - bs0), 64'd32);

    // 3: sink blocked, credit limit, then full drain
    do_reset();
    n_iss = 0;
    for (int c = 0; c < 60; c++) begin
      logic iss;
      iss = issue_ok_o;
      if (iss) n_iss++;
      cycle(iss, mk_pair(100 + n_iss), 1'b0);
    end
    chk("credit_issues", 64'(n_iss), 64'd16);
    chk("credit_ok_low", 64'(issue_ok_o), 64'd0);
    chk("credit_no_err", 64'(err_o), 64'd0);
    bs0 = beats_seen;
    drain(200, 1'b0);
    chk("credit_drain_beats", 64'(beats_seen - bs0), 64'd128);
    chk("credit_ok_back", 64'(issue_ok_o), 64'd1);

    // 4: 1-0-0-1 backpressure
    do_reset();
    cycle(1'b1, mk_pair(200), 1'b1);
    cycle(1'b1, mk_pair(201), 1'b1);
    cycle(1'b1, mk_pair(202), 1'b0);
    drain(120, 1'b1);

    // 5a: valid with nothing in flight -> sticky error, data still delivered
    do_reset();
    pipe_v[7] = 1'b1;
    pipe_d[7] = mk_pair(300);
    cycle(1'b0, '0, 1'b0);
    chk("err_orphan_valid", 64'(err_o), 64'd1);
    drain(40, 1'b0);
    chk("err_sticky", 64'(err_o), 64'd1);
    do_reset();
    chk("err_cleared", 64'(err_o), 64'd0);

    // 5b: issue without credit -> sticky error
    for (int c = 0; c < 30; c++) cycle(issue_ok_o, mk_pair(400 + c), 1'b0);
    chk("ovf_no_err_yet", 64'(err_o), 64'd0);
    chk("ovf_ok_low", 64'(issue_ok_o), 64'd0);
    cycle(1'b1, mk_pair(499), 1'b0);
    chk("ovf_err", 64'(err_o), 64'd1);
    repeat (12) cycle(1'b0, '0, 1'b0);
    chk("ovf_err_sticky", 64'(err_o), 64'd1);
    do_reset();
    chk("ovf_err_cleared", 64'(err_o), 64'd0);

    // 6: asynchronous reset at beat 3 of pair 2, then a fresh packet
    for (int k = 0; k < 4; k++) cycle(1'b1, mk_pair(600 + k), 1'b1);
    bs0 = beats_seen;
    for (int c = 0; c < 60 && (beats_seen - bs0) < 11; c++) cycle(1'b0, '0, 1'b1);
    chk("mid_reached", 64'(beats_seen - bs0), 64'd11);
    chk("mid_valid", 64'(m_valid_o), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_valid", 64'(m_valid_o), 64'd0);
    do_reset();
    bs0 = beats_seen;
    for (int k = 0; k < 4; k++) cycle(1'b1, mk_pair(700 + k), 1'b1);
    drain(80, 1'b0);
    chk("post_rst_beats", 64'(beats_seen - bs0), 64'd32);
    chk("post_rst_err", 64'(err_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
